// File: rtl/interrupt_controller.sv
// interrupt_controller: timer tick + keyboard interrupt responder for the game CPU.
// Build option KEY_FIFO_EN: 4-entry key FIFO instead of a single key latch.
`timescale 1ns/1ps
module interrupt_controller #(
  parameter int unsigned TIMER_PERIOD = 833333,
  parameter int unsigned TIMER_WIDTH  = 20
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       KBD_STROBE,
  input  logic [7:0] KBD_DATA,
  output logic [1:0] INT_IRQ,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic [7:0] KBD_KEY,
  output logic       TIMER_OVERRUN,
  output logic       KEY_OVERRUN,
  input  logic       CLR_OVERRUN
);

  localparam logic [1:0] IRQ_TIMER = 2'b00;
  localparam logic [1:0] IRQ_KBD   = 2'b01;
  localparam logic [1:0] IRQ_NONE  = 2'b11;

  localparam logic [TIMER_WIDTH-1:0] TICK_LAST =
    TIMER_WIDTH'(TIMER_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_T   = 2'd1,
    REQ_K   = 2'd2,
    SERVICE = 2'd3
  } ctrlState_e;

  ctrlState_e state;
  ctrlState_e stateNext;
  logic [1:0] irqNext;

  logic [TIMER_WIDTH-1:0] tickCnt;
  logic tickWrap;
  logic timerPend;
  logic timerOvrSet;
  logic clrTimer;

  logic popKey;
  logic keyAvail;
  logic keyDrop;
  logic keyPush;
  logic [7:0] keyHead;

  // Free-running tick counter, independent of the handshake state.
  assign tickWrap = (tickCnt == TICK_LAST);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tickCnt <= '0;
    end else if (tickWrap) begin
      tickCnt <= '0;
    end else begin
      tickCnt <= tickCnt + TIMER_WIDTH'(1);
    end
  end

  // A wrap on the acknowledge cycle re-arms the tick without an overrun.
  assign timerOvrSet = tickWrap & timerPend & ~clrTimer;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      timerPend <= 1'b0;
    end else if (tickWrap) begin
      timerPend <= 1'b1;
    end else if (clrTimer) begin
      timerPend <= 1'b0;
    end
  end

`ifdef KEY_FIFO_EN
  logic [7:0] keyMem [4];
  logic [1:0] wrPtr;
  logic [1:0] rdPtr;
  logic [2:0] keyCount;
  logic keyFull;

  assign keyFull  = (keyCount == 3'd4);
  assign keyAvail = (keyCount != 3'd0);
  assign keyPush  = KBD_STROBE & (~keyFull | popKey);
  assign keyDrop  = KBD_STROBE & keyFull & ~popKey;
  assign keyHead  = keyMem[rdPtr];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      keyCount <= '0;
    end else begin
      if (keyPush) begin
        wrPtr <= wrPtr + 2'd1;
      end
      if (popKey) begin
        rdPtr <= rdPtr + 2'd1;
      end
      keyCount <= keyCount
                + {2'b00, keyPush}
                - {2'b00, popKey};
    end
  end

  always_ff @(posedge CLK) begin
    if (keyPush) begin
      keyMem[wrPtr] <= KBD_DATA;
    end
  end
`else
  logic [7:0] keyLatch;
  logic keyValid;

  assign keyAvail = keyValid;
  assign keyPush  = KBD_STROBE & (~keyValid | popKey);
  assign keyDrop  = KBD_STROBE & keyValid & ~popKey;
  assign keyHead  = keyLatch;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      keyLatch <= 8'h00;
      keyValid <= 1'b0;
    end else if (keyPush) begin
      keyLatch <= KBD_DATA;
      keyValid <= 1'b1;
    end else if (popKey) begin
      keyValid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= IDLE;
      INT_IRQ <= IRQ_NONE;
    end else begin
      state   <= stateNext;
      INT_IRQ <= irqNext;
    end
  end

  // Once a code is presented it is held until acknowledged.
  always_comb begin
    stateNext = state;
    irqNext   = INT_IRQ;
    popKey    = 1'b0;
    clrTimer  = 1'b0;
    unique case (state)
      IDLE: begin
        irqNext = IRQ_NONE;
        if (timerPend) begin
          stateNext = REQ_T;
          irqNext   = IRQ_TIMER;
        end else if (keyAvail) begin
          stateNext = REQ_K;
          irqNext   = IRQ_KBD;
        end
      end
      REQ_T: begin
        if (INT_IACK) begin
          stateNext = SERVICE;
          irqNext   = IRQ_NONE;
          clrTimer  = 1'b1;
        end
      end
      REQ_K: begin
        if (INT_IACK) begin
          stateNext = SERVICE;
          irqNext   = IRQ_NONE;
          popKey    = 1'b1;
        end
      end
      SERVICE: begin
        irqNext = IRQ_NONE;
        if (INT_IEND) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        irqNext   = IRQ_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      KBD_KEY <= 8'h00;
    end else if (popKey) begin
      KBD_KEY <= keyHead;
    end
  end

  // Sticky flags: a new event outranks a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      TIMER_OVERRUN <= 1'b0;
      KEY_OVERRUN   <= 1'b0;
    end else begin
      if (timerOvrSet) begin
        TIMER_OVERRUN <= 1'b1;
      end else if (CLR_OVERRUN) begin
        TIMER_OVERRUN <= 1'b0;
      end
      if (keyDrop) begin
        KEY_OVERRUN <= 1'b1;
      end else if (CLR_OVERRUN) begin
        KEY_OVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: vector table, corner sequences and random
// stimulus against a queue-based reference model (timer period 8).
`timescale 1ns/1ps
module tb_interrupt_controller;

  localparam int P = 8;
`ifdef KEY_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_TIMER = 1;
  localparam int PH_KEY   = 2;
  localparam int PH_SVC   = 3;

  logic       CLK;
  logic       RESET_N;
  logic       KBD_STROBE;
  logic [7:0] KBD_DATA;
  logic [1:0] INT_IRQ;
  logic       INT_IACK;
  logic       INT_IEND;
  logic [7:0] KBD_KEY;
  logic       TIMER_OVERRUN;
  logic       KEY_OVERRUN;
  logic       CLR_OVERRUN;

  interrupt_controller #(
    .TIMER_PERIOD(P),
    .TIMER_WIDTH (20)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .KBD_STROBE   (KBD_STROBE),
    .KBD_DATA     (KBD_DATA),
    .INT_IRQ      (INT_IRQ),
    .INT_IACK     (INT_IACK),
    .INT_IEND     (INT_IEND),
    .KBD_KEY      (KBD_KEY),
    .TIMER_OVERRUN(TIMER_OVERRUN),
    .KEY_OVERRUN  (KEY_OVERRUN),
    .CLR_OVERRUN  (CLR_OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nVec = 0;
  int nMis = 0;

  // Reference model
  int         mTick;
  bit         mPend;
  int         mPhase;
  logic [7:0] q[$];
  logic [1:0] mIrq;
  logic [7:0] mKey;
  bit         mTovr;
  bit         mKovr;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input bit rst, input bit stb,
                           input logic [7:0] d, input bit ack,
                           input bit iend, input bit clr);
    bit wrap, pop, tAck, setT, setK;
    if (!rst) begin
      mTick = 0;
      mPend = 0;
      mPhase = PH_IDLE;
      q.delete();
      mIrq = 2'b11;
      mKey = 8'h00;
      mTovr = 0;
      mKovr = 0;
      return;
    end
    wrap = (mTick == P - 1);
    mTick = wrap ? 0 : mTick + 1;
    pop = (mPhase == PH_KEY) && ack;
    tAck = (mPhase == PH_TIMER) && ack;
    setT = wrap && mPend && !tAck;
    setK = stb && (q.size() >= CAP) && !pop;
    case (mPhase)
      PH_IDLE: begin
        if (mPend) begin
          mPhase = PH_TIMER;
          mIrq = 2'b00;
        end else if (q.size() > 0) begin
          mPhase = PH_KEY;
          mIrq = 2'b01;
        end
      end
      PH_TIMER: if (ack) begin
        mPhase = PH_SVC;
        mIrq = 2'b11;
      end
      PH_KEY: if (ack) begin
        mPhase = PH_SVC;
        mIrq = 2'b11;
        mKey = q[0];
      end
      default: if (iend) mPhase = PH_IDLE;
    endcase
    if (wrap) mPend = 1;
    else if (tAck) mPend = 0;
    if (pop) void'(q.pop_front());
    if (stb && !setK) q.push_back(d);
    mTovr = setT | (mTovr & ~clr);
    mKovr = setK | (mKovr & ~clr);
  endtask

  task automatic drive(input bit rst, input bit stb,
                       input logic [7:0] d, input bit ack,
                       input bit iend, input bit clr);
    RESET_N = rst;
    KBD_STROBE = stb;
    KBD_DATA = d;
    INT_IACK = ack;
    INT_IEND = iend;
    CLR_OVERRUN = clr;
    @(posedge CLK);
    modelStep(rst, stb, d, ack, iend, clr);
    #1;
  endtask

  task automatic cycle(input bit rst, input bit stb,
                       input logic [7:0] d, input bit ack,
                       input bit iend, input bit clr);
    drive(rst, stb, d, ack, iend, clr);
    chk("irq", 8'(INT_IRQ), 8'(mIrq));
    chk("key", KBD_KEY, mKey);
    chk("tovr", 8'(TIMER_OVERRUN), 8'(mTovr));
    chk("kovr", 8'(KEY_OVERRUN), 8'(mKovr));
  endtask

  task automatic idle();
    cycle(1, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic doReset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 0, 0, 0);
  endtask

  typedef struct {
    bit         rst;
    bit         stb;
    logic [7:0] data;
    bit         ack;
    bit         iend;
    bit         clr;
    logic [1:0] irq;
    logic [7:0] key;
    bit         tovr;
    bit         kovr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [7:0] order[4];
    int grants;

    RESET_N = 1'b0;
    KBD_STROBE = 1'b0;
    KBD_DATA = 8'h00;
    INT_IACK = 1'b0;
    INT_IEND = 1'b0;
    CLR_OVERRUN = 1'b0;

    // Reset, key grant, first tick, stray IEND
    tbl[0]  = '{0, 0, 8'h00, 0, 0, 0, 2'b11, 8'h00, 0, 0};
    tbl[1]  = '{0, 0, 8'h00, 0, 0, 0, 2'b11, 8'h00, 0, 0};
    tbl[2]  = '{0, 0, 8'h00, 0, 0, 0, 2'b11, 8'h00, 0, 0};
    tbl[3]  = '{1, 1, 8'h77, 0, 0, 0, 2'b11, 8'h00, 0, 0};
    tbl[4]  = '{1, 0, 8'h00, 0, 0, 0, 2'b01, 8'h00, 0, 0};
    tbl[5]  = '{1, 0, 8'h00, 1, 0, 0, 2'b11, 8'h77, 0, 0};
    tbl[6]  = '{1, 0, 8'h00, 0, 1, 0, 2'b11, 8'h77, 0, 0};
    tbl[7]  = '{1, 0, 8'h00, 0, 0, 0, 2'b11, 8'h77, 0, 0};
    tbl[8]  = '{1, 0, 8'h00, 0, 0, 0, 2'b11, 8'h77, 0, 0};
    tbl[9]  = '{1, 0, 8'h00, 0, 0, 0, 2'b11, 8'h77, 0, 0};
    tbl[10] = '{1, 0, 8'h00, 0, 0, 0, 2'b11, 8'h77, 0, 0};
    tbl[11] = '{1, 0, 8'h00, 0, 0, 0, 2'b00, 8'h77, 0, 0};
    tbl[12] = '{1, 0, 8'h00, 1, 0, 0, 2'b11, 8'h77, 0, 0};
    tbl[13] = '{1, 0, 8'h00, 0, 1, 0, 2'b11, 8'h77, 0, 0};
    tbl[14] = '{1, 0, 8'h00, 0, 1, 0, 2'b11, 8'h77, 0, 0};
    tbl[15] = '{1, 0, 8'h00, 0, 0, 0, 2'b11, 8'h77, 0, 0};

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stb, tbl[i].data,
            tbl[i].ack, tbl[i].iend, tbl[i].clr);
      chk($sformatf("tbl%0d_irq", i), 8'(INT_IRQ), 8'(tbl[i].irq));
      chk($sformatf("tbl%0d_key", i), KBD_KEY, tbl[i].key);
      chk($sformatf("tbl%0d_tovr", i),
          8'(TIMER_OVERRUN), 8'(tbl[i].tovr));
      chk($sformatf("tbl%0d_kovr", i),
          8'(KEY_OVERRUN), 8'(tbl[i].kovr));
    end

    // Tick and strobe on the same cycle: timer first
    doReset();
    for (int i = 0; i < 7; i++) idle();
    cycle(1, 1, 8'h20, 0, 0, 0);
    idle();
    chk("prio_timer", 8'(INT_IRQ), 8'h00);
    cycle(1, 0, 8'h00, 1, 0, 0);
    cycle(1, 0, 8'h00, 0, 1, 0);
    idle();
    chk("prio_kbd", 8'(INT_IRQ), 8'h01);
    cycle(1, 0, 8'h00, 1, 0, 0);
    chk("prio_key", KBD_KEY, 8'h20);
    cycle(1, 0, 8'h00, 0, 1, 0);

    // Timer overrun, clear, and ack on a wrap cycle
    doReset();
    for (int i = 0; i < 20; i++) idle();
    chk("tovr_set", 8'(TIMER_OVERRUN), 8'h01);
    chk("tovr_held", 8'(INT_IRQ), 8'h00);
    cycle(1, 0, 8'h00, 0, 0, 1);
    chk("tovr_clr", 8'(TIMER_OVERRUN), 8'h00);
    idle();
    idle();
    cycle(1, 0, 8'h00, 1, 0, 0);
    chk("ack_wrap_novr", 8'(TIMER_OVERRUN), 8'h00);
    cycle(1, 0, 8'h00, 0, 1, 0);
    idle();
    chk("ack_wrap_rearm", 8'(INT_IRQ), 8'h00);
    cycle(1, 0, 8'h00, 1, 0, 0);
    cycle(1, 0, 8'h00, 0, 1, 0);

    // Key overrun
    doReset();
`ifdef KEY_FIFO_EN
    order[0] = 8'h77;
    order[1] = 8'h73;
    order[2] = 8'h69;
    order[3] = 8'h6B;
    cycle(1, 1, 8'h77, 0, 0, 0);
    cycle(1, 1, 8'h73, 0, 0, 0);
    cycle(1, 1, 8'h69, 0, 0, 0);
    cycle(1, 1, 8'h6B, 0, 0, 0);
    cycle(1, 1, 8'h20, 0, 0, 0);
    chk("kovr_fifo", 8'(KEY_OVERRUN), 8'h01);
    grants = 0;
    for (int n = 0; n < 120; n++) begin
      if (INT_IRQ == 2'b01) begin
        cycle(1, 0, 8'h00, 1, 0, 0);
        if (grants < 4)
          chk("fifo_order", KBD_KEY, order[grants]);
        grants++;
        cycle(1, 0, 8'h00, 0, 1, 0);
      end else if (INT_IRQ == 2'b00) begin
        cycle(1, 0, 8'h00, 1, 0, 0);
        cycle(1, 0, 8'h00, 0, 1, 0);
      end else begin
        idle();
      end
    end
    chk("fifo_grants", 8'(grants), 8'd4);
`else
    order[0] = 8'h77;
    cycle(1, 1, 8'h77, 0, 0, 0);
    cycle(1, 1, 8'h73, 0, 0, 0);
    chk("kovr_latch", 8'(KEY_OVERRUN), 8'h01);
    cycle(1, 0, 8'h00, 1, 0, 0);
    chk("latch_key", KBD_KEY, order[0]);
    cycle(1, 0, 8'h00, 0, 1, 0);
    cycle(1, 0, 8'h00, 0, 1, 0);
    idle();
    chk("stray_iend", 8'(INT_IRQ), 8'h03);
`endif
    cycle(1, 0, 8'h00, 0, 0, 1);
    chk("kovr_clr", 8'(KEY_OVERRUN), 8'h00);

    // Random traffic against the model
    doReset();
    for (int n = 0; n < 4000; n++) begin
      bit rst, stb, ack, iend, clr;
      rst  = ($urandom_range(0, 399) != 0);
      stb  = ($urandom_range(0, 5) == 0);
      ack  = ($urandom_range(0, 2) == 0);
      iend = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      cycle(rst, stb, 8'($urandom), ack, iend, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nMis);
    $finish;
  end

endmodule
